muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit that sits directly downstream of the ALU control decoder.
- It consumes the 5-bit ALU_CONTROL codes for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) and produces a 32-bit result after a fixed multi-cycle latency.
- Radix-2 shift-add / restoring-divide datapath, one bit per clock.
- Start/busy/done handshake, used by the hazard unit to stall the pipeline.

Parameters:
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.

Ports:
- CLK  input  1  system clock, rising edge
- RESETN  input  1  asynchronous active-low reset
- START  input  1  request; sampled only while BUSY=0
- ALU_CONTROL  input  5  operation code from the ALU control decoder
- DATA1  input  DATA_WIDTH  rs1 operand (dividend / multiplicand)
- DATA2  input  DATA_WIDTH  rs2 operand (divisor / multiplier)
- RESULT  output  DATA_WIDTH  registered result; holds until the next DONE
- BUSY  output  1  high while an operation is in flight
- DONE  output  1  one-cycle pulse, coincident with RESULT becoming valid

Behaviour:
- Reset: one clock (CLK), asynchronous active-low reset (RESETN).
  - RESETN low forces state IDLE, RESULT=0, BUSY=0, DONE=0, counter=0, internal registers=0, immediately and without waiting for a clock edge.
  - Reset asserted mid-operation aborts the operation; no DONE is produced.
- Valid ALU_CONTROL codes:
  - 01010 MUL, 01011 MULH, 01100 MULHSU, 01101 MULHU
  - 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU
  - START with any other code is ignored: state stays IDLE, no BUSY, no DONE.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with START=1 and a valid code, latch the opcode and both operands.
  - Record operand signs:
    - DATA1 sign for MULH, MULHSU, DIV, REM.
    - DATA2 sign for MULH, DIV, REM.
  - Convert signed operands to magnitudes.
  - Clear the counter and go to CALC, or go directly to FIX on a special case.
  - DONE=0 in every IDLE cycle except the pulse cycle defined under FIX.
- CALC:
  - One iteration per edge.
  - Multiply: 2*DATA_WIDTH-bit unsigned shift-add accumulator.
  - Divide: restoring division, DATA_WIDTH-bit quotient and remainder.
  - After exactly DATA_WIDTH iterations, go to FIX.
- FIX, single edge:
  - Negate the 64-bit product if the operand signs differ (signed-aware ops).
  - Negate the quotient if the DIV signs differ.
  - Give the remainder the sign of the dividend (REM).
  - Select the output: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register RESULT, set DONE=1, return to IDLE.
- Latency, normal operation:
  - START sampled at edge 0; CALC occupies edges 1..32; FIX at edge 33.
  - DONE=1 and RESULT valid in the cycle following edge 33.
  - BUSY=1 from after edge 0 until edge 33. BUSY=0 during the DONE cycle.
  - A new START is accepted in the DONE cycle (back-to-back operation).
- Special cases (fast path):
  - Edge 0 goes to FIX; DONE follows edge 1.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000; REM gives 0.
- START while BUSY=1 is ignored and does not disturb the latched operands.
- Operand or ALU_CONTROL changes after edge 0 have no effect on the operation in flight.
- RESULT is unchanged except on the FIX edge.

Test Plan:
- Reset, then MUL 7 x 0xFFFFFFFD (-3) -> RESULT 0xFFFFFFEB, DONE a single-cycle pulse after edge 33, BUSY high for 33 cycles.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
- Division with negative dividend:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD
  - REM -7 % 2 -> 0xFFFFFFFF
  - DIVU 100 / 7 -> 14
  - REMU 100 % 7 -> 2
  - Issue back to back, each START in the prior DONE cycle.
- Fast path:
  - DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 % 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Each: DONE after edge 1, BUSY high one cycle.
- Ignored requests:
  - START with ALU_CONTROL=00010 -> no BUSY, no DONE, RESULT unchanged.
  - START pulsed mid-CALC with new operands -> original result unaffected, exactly one DONE.
- Reset mid-operation: drive RESETN low at iteration 10 -> BUSY/DONE/RESULT go 0 immediately; after release, a new MUL 3 x 4 -> 12.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the ALU control decoder and the multiply/divide unit.
// The master issues START with an operation; the slave answers with BUSY, DONE and RESULT.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  START;
    logic [4:0]            ALU_CONTROL;
    logic [DATA_WIDTH-1:0] DATA1;
    logic [DATA_WIDTH-1:0] DATA2;
    logic [DATA_WIDTH-1:0] RESULT;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        output START, ALU_CONTROL, DATA1, DATA2,
        input  RESULT, BUSY, DONE
    );

    modport slave (
        input  START, ALU_CONTROL, DATA1, DATA2,
        output RESULT, BUSY, DONE
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add and restoring divide, one bit per clock.
// Latency: DONE one cycle after edge DATA_WIDTH+1 (edge 1 for divide-by-zero/overflow fast path).
// Backpressure: START is only sampled while BUSY=0; requests while busy are dropped.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RESETN,
    muldiv_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic logic is_valid_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    state_t          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            fast_q, fast_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;
    logic            done_q, done_d;

    logic            sign_a, sign_b;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift, div_diff;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_fix, rem_fix;

    // Signs only matter for the signed-aware ops; everything else runs on raw bits.
    assign sign_a = bus.DATA1[W-1] &
                    (bus.ALU_CONTROL inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sign_b = bus.DATA2[W-1] & (bus.ALU_CONTROL inside {OP_MULH, OP_DIV, OP_REM});
    assign a_mag  = sign_a ? -bus.DATA1 : bus.DATA1;
    assign b_mag  = sign_b ? -bus.DATA2 : bus.DATA2;

    // acc holds {high product, remaining multiplier} or {partial remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        fast_d   = fast_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START && is_valid_op(bus.ALU_CONTROL)) begin
                    op_d    = bus.ALU_CONTROL;
                    neg_a_d = sign_a;
                    neg_b_d = sign_b;
                    cnt_d   = '0;
                    fast_d  = 1'b0;
                    state_d = CALC;
                    if (is_div_op(bus.ALU_CONTROL)) begin
                        opnd_d = b_mag;
                        acc_d  = {{W{1'b0}}, a_mag};
                        if (bus.DATA2 == '0) begin
                            fast_d  = 1'b1;
                            state_d = FIX;
                            acc_d   = {{W{1'b0}},
                                       (is_rem_op(bus.ALU_CONTROL) ? bus.DATA1 : {W{1'b1}})};
                        end else if ((bus.ALU_CONTROL inside {OP_DIV, OP_REM}) &&
                                     (bus.DATA1 == MIN_NEG) && (bus.DATA2 == {W{1'b1}})) begin
                            fast_d  = 1'b1;
                            state_d = FIX;
                            acc_d   = {{W{1'b0}},
                                       (is_rem_op(bus.ALU_CONTROL) ? {W{1'b0}} : MIN_NEG)};
                        end
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{W{1'b0}}, b_mag};
                    end
                end
            end

            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_op(op_q)) begin
                    if (div_diff[W])
                        acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
                    else
                        acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                if (cnt_q == CW'(W - 1))
                    state_d = FIX;
            end

            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (fast_q) begin
                    result_d = acc_q[W-1:0];
                end else begin
                    case (op_q)
                        OP_MUL:                        result_d = prod_fix[W-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*W-1:W];
                        OP_DIV, OP_DIVU:               result_d = quot_fix;
                        default:                       result_d = rem_fix;
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            fast_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            fast_q   <= fast_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.RESULT = result_q;
    assign bus.BUSY   = (state_q != IDLE);
    assign bus.DONE   = done_q;
endmodule
